// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one SPI_Master among NUM_REQ requesters.
// It launches one transfer per grant, captures the received word and signals completion.
module spi_req_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int BITS_NUM = 8,
  parameter int TIMEOUT  = 64,
  parameter int GAP      = 2,
  parameter int SEL_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BITS_NUM-1:0]  req_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         err,
  output logic [BITS_NUM-1:0]          rx_data,
  output logic [SEL_W-1:0]             sel,
  output logic                         busy,
  output logic                         m_tx_start,
  output logic [BITS_NUM-1:0]          m_data_in,
  input  logic                         m_tx_end,
  input  logic [BITS_NUM-1:0]          m_data_out,
  output logic [2:0]                   state_dbg
);

  // Requester handshake: req[i] is a level held high until done[i] pulses; grant[i]
  // marks ownership from START through DONE, and req is only sampled while IDLE.

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_BUSY    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int CW    = SEL_W + 1;

  logic [2:0]       state;
  logic [SEL_W-1:0] rr_ptr;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             tx_end_q;
  logic             tx_end_rise;

  logic [SEL_W-1:0] win_idx;
  logic             win_vld;
  logic [CW-1:0]    cand;

  assign tx_end_rise = m_tx_end & ~tx_end_q;
  assign busy        = (state != S_IDLE);
  assign state_dbg   = state;

  // First set request strictly after the last winner, wrapping around.
  always_comb begin
    win_idx = rr_ptr;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!win_vld && req[cand[SEL_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[SEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      grant      <= '0;
      done       <= '0;
      err        <= 1'b0;
      rx_data    <= '0;
      sel        <= '0;
      m_tx_start <= 1'b0;
      m_data_in  <= '0;
      rr_ptr     <= SEL_W'(NUM_REQ - 1);
      to_cnt     <= '0;
      gap_cnt    <= '0;
      tx_end_q   <= 1'b0;
    end else begin
      tx_end_q   <= m_tx_end;
      m_tx_start <= 1'b0;
      done       <= '0;
      err        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            sel       <= win_idx;
            grant     <= NUM_REQ'(1) << win_idx;
            m_data_in <= req_data[int'(win_idx)*BITS_NUM +: BITS_NUM];
            rr_ptr    <= win_idx;
            state     <= S_START;
          end
        end
        S_START: begin
          m_tx_start <= 1'b1;
          to_cnt     <= '0;
          state      <= S_BUSY;
        end
        S_BUSY: begin
          to_cnt <= to_cnt + TO_W'(1);
          // A fresh edge wins over the timeout; the stale-high level is ignored.
          if (tx_end_rise) begin
            state <= S_CAPTURE;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            rx_data <= '0;
            done    <= grant;
            err     <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_CAPTURE: begin
          rx_data <= m_data_out;
          done    <= grant;
          state   <= S_DONE;
        end
        S_DONE: begin
          grant   <= '0;
          gap_cnt <= '0;
          state   <= (GAP == 0) ? S_IDLE : S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP - 1)) state <= S_IDLE;
          else gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed plus randomized bench for spi_req_arbiter with a behavioural SPI master
// and a round-robin reference model.
module tb_spi_req_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           err;
  logic [W-1:0]   rx_data;
  logic [1:0]     sel;
  logic           busy;
  logic           m_tx_start;
  logic [W-1:0]   m_data_in;
  logic           m_tx_end;
  logic [W-1:0]   m_data_out;
  logic [2:0]     state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_win;
  int done_t;
  logic [W-1:0] exp_q[$];

  spi_req_arbiter #(.NUM_REQ(N), .BITS_NUM(W), .TIMEOUT(64), .GAP(2)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .err(err), .rx_data(rx_data), .sel(sel),
    .busy(busy), .m_tx_start(m_tx_start), .m_data_in(m_data_in),
    .m_tx_end(m_tx_end), .m_data_out(m_data_out), .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant must never name more than one requester.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      total++;
      assert ($countones(grant) <= 1) else begin
        bad++;
        $error("FAIL grant_onehot: observed=%0h expected=at most one bit", grant);
      end
    end
  end

  // Reference arbitration: first requester after the previous winner, with wrap.
  function automatic int pick(input logic [N-1:0] r, input int after);
    int j;
    pick = -1;
    for (int k = 1; k <= N; k++) begin
      j = (after + k) % N;
      if (pick < 0 && r[j]) pick = j;
    end
  endfunction

  // Driver: plays the SPI master for one granted transfer and checks the sequence.
  task automatic do_xfer(input int idx, input logic [W-1:0] resp, input int dly,
                         input bit tmo, input bit drop, input bit keep,
                         input int t_ref, input int exp_dist);
    logic [N-1:0] oh;
    logic [W-1:0] txw;
    logic [W-1:0] exp_rx;
    int n;
    oh  = 4'b0001 << idx;
    txw = req_data[idx*W +: W];
    exp_q.push_back(tmo ? 8'h00 : resp);
    n = 0;
    while (m_tx_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tx_start_seen", 32'(m_tx_start), 32'd1);
    if (m_tx_start !== 1'b1) begin
      void'(exp_q.pop_front());
      return;
    end
    if (exp_dist >= 0) chk("start_latency", 32'(cyc - t_ref), 32'(exp_dist));
    chk("grant", 32'(grant), 32'(oh));
    chk("sel", 32'(sel), 32'(idx));
    chk("m_data_in", 32'(m_data_in), 32'(txw));
    chk("busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("tx_start_pulse", 32'(m_tx_start), 32'd0);
    m_tx_end = 1'b0;
    if (drop) req[idx] = 1'b0;
    if (!tmo) begin
      repeat (dly - 1) @(negedge clk);
      m_tx_end   = 1'b1;
      m_data_out = resp;
    end
    n = 0;
    while (done === '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", 32'(n), tmo ? 32'd63 : 32'd2);
    chk("done", 32'(done), 32'(oh));
    chk("err", 32'(err), 32'(tmo));
    chk("grant_at_done", 32'(grant), 32'(oh));
    chk("m_data_in_held", 32'(m_data_in), 32'(txw));
    exp_rx = exp_q.pop_front();
    chk("rx_data", 32'(rx_data), 32'(exp_rx));
    done_t   = cyc;
    last_win = idx;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("err_pulse", 32'(err), 32'd0);
    chk("grant_gap", 32'(grant), 32'd0);
    chk("busy_gap", 32'(busy), 32'd1);
    chk("rx_held", 32'(rx_data), 32'(exp_rx));
    if (!keep) req[idx] = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    m_tx_end = 1'b0;
    m_data_out = '0;
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_win = N - 1;
    @(negedge clk);
  endtask

  initial begin
    int t;
    int idx;
    int n;
    reset = 1'b1; req = '0; req_data = '0; m_tx_end = 1'b0; m_data_out = '0;
    last_win = N - 1; done_t = 0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rx", 32'(rx_data), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_start", 32'(m_tx_start), 32'd0);
    chk("rst_data_in", 32'(m_data_in), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single request
    req_data[7:0] = 8'hA5; req = 4'b0001; t = cyc;
    do_xfer(pick(req, last_win), 8'h3C, $urandom_range(2, 10), 0, 0, 0, t, 2);

    // Timeout, then a normal transfer, then tx_end rising on the last timeout cycle
    req_data[15:8] = 8'($urandom); req = 4'b0010;
    do_xfer(pick(req, last_win), 8'h00, 0, 1, 0, 0, done_t, 5);
    req_data[31:24] = 8'($urandom); req = 4'b1000;
    do_xfer(pick(req, last_win), 8'($urandom), $urandom_range(2, 10), 0, 0, 0, done_t, 5);
    req_data[23:16] = 8'($urandom); req = 4'b0100;
    do_xfer(pick(req, last_win), 8'($urandom), 63, 0, 0, 0, done_t, 5);

    // All requesting, each reacquiring after its done
    pulse_reset();
    req_data = {$urandom, $urandom};
    req = 4'b1111; t = cyc;
    for (int r = 0; r < 5; r++) begin
      idx = pick(req, last_win);
      do_xfer(idx, 8'($urandom), $urandom_range(2, 12), 0, 0, 1,
              (r == 0) ? t : done_t, (r == 0) ? 2 : 5);
    end
    req = '0;
    repeat (4) @(negedge clk);

    // Reset in the middle of a transfer
    req_data[7:0] = 8'($urandom); req = 4'b0001;
    n = 0;
    while (m_tx_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mid_tx_start_seen", 32'(m_tx_start), 32'd1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_data_in", 32'(m_data_in), 32'd0);
    pulse_reset();
    chk("mid_rst_no_done", 32'(done), 32'd0);
    req_data[23:16] = 8'($urandom); req = 4'b0100; t = cyc;
    do_xfer(pick(req, last_win), 8'($urandom), $urandom_range(2, 10), 0, 0, 0, t, 2);

    // Request withdrawn while busy
    req_data[23:16] = 8'h5A; req = 4'b0100;
    do_xfer(pick(req, last_win), 8'($urandom), $urandom_range(4, 10), 0, 1, 0, done_t, 5);
    repeat (10) @(negedge clk);
    chk("withdrawn_no_regrant", 32'(grant), 32'd0);
    chk("withdrawn_idle", 32'(busy), 32'd0);

    // Random request patterns, occasionally timing out
    req_data = {$urandom, $urandom};
    req = 4'($urandom_range(1, 15)); t = cyc;
    for (int r = 0; r < 12; r++) begin
      idx = pick(req, last_win);
      if ($urandom_range(0, 5) == 0)
        do_xfer(idx, 8'h00, 0, 1, 0, 1, (r == 0) ? t : done_t, (r == 0) ? 2 : 5);
      else
        do_xfer(idx, 8'($urandom), $urandom_range(2, 20), 0, 0, 1,
                (r == 0) ? t : done_t, (r == 0) ? 2 : 5);
      req_data = {$urandom, $urandom};
      req = 4'($urandom_range(1, 15));
    end
    req = '0;
    repeat (6) @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
Round-robin arbiter and transaction sequencer that shares one SPI_Master instance among NUM_REQ requesters. It latches the winning requester's byte and pulses the master's tx_start. It then tracks tx_end, captures the master's registered data_out and returns it to the requester with a done pulse. A timeout aborts transactions whose tx_end never rises. A select index drives the external per-slave chip-select demux.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
BITS_NUM, 8, SPI word width; must equal the SPI_Master bits_num
TIMEOUT, 64, max cycles in BUSY waiting for tx_end rise before abort
GAP, 2, idle cycles after DONE before next arbitration (ss high time)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
req  in  NUM_REQ  level request per requester; held until its done
req_data  in  NUM_REQ*BITS_NUM  tx word; requester i at [i*BITS_NUM +: BITS_NUM]
grant  out  NUM_REQ  one-hot; high for the granted requester from START through DONE
done  out  NUM_REQ  one-cycle pulse to the granted requester at completion
err  out  1  one-cycle pulse coincident with done when the transaction timed out
rx_data  out  BITS_NUM  received word; valid in the done cycle, held until next DONE
sel  out  $clog2(NUM_REQ)  index of current/last granted requester
busy  out  1  high in every state except IDLE
m_tx_start  out  1  to SPI_Master tx_start
m_data_in  out  BITS_NUM  to SPI_Master data_in
m_tx_end  in  1  from SPI_Master tx_end
m_data_out  in  BITS_NUM  from SPI_Master data_out

Behaviour:
- Reset (async, active-high): state IDLE; grant, done, err, m_tx_start, busy = 0; rx_data, m_data_in, sel = 0; timeout and gap counters = 0; rr pointer = NUM_REQ-1, so requester 0 has first priority; tx_end_q = 0. Reset mid-transaction abandons it with no done pulse. The SPI_Master must be reset in the same cycle by the system.
- tx_end_q <= m_tx_end every cycle. tx_end_rise = m_tx_end & ~tx_end_q.
- States: IDLE, START, BUSY, CAPTURE, DONE, GAP.
- IDLE: if req != 0, winner = first set bit searching from rr pointer+1 upward with wrap. Register sel = winner, grant = onehot(winner), m_data_in = req_data slice, rr pointer = winner; go to START. If req == 0, stay.
- START: m_tx_start = 1 for exactly this one cycle. Clear the timeout counter. Go to BUSY.
- BUSY: timeout counter increments each cycle.
  - If tx_end_rise: go to CAPTURE.
  - Else if counter == TIMEOUT-1: go to DONE with err flagged and rx_data = 0.
  - tx_end_rise wins if it occurs in the same cycle as the timeout.
  - The stale-high tx_end from the previous transaction falls after tx_start; only a fresh rising edge counts.
- CAPTURE: one cycle. The master updates data_out on the edge entering this state. On exit, rx_data <= m_data_out. Go to DONE.
- DONE: one cycle. done[sel] = 1; err = 1 only on the timeout path. grant drops on exit. Go to GAP.
- GAP: GAP cycles with busy = 1, grant = 0, then IDLE. When GAP = 0, go straight to IDLE.
- m_data_in is held stable from START until the next IDLE win, because the master samples data_in throughout the transfer.
- req drops while granted: the transaction completes normally; done still pulses.
- req changes in non-IDLE states are ignored until the next IDLE.
- Latency from req rise (arbiter idle) to m_tx_start: 2 cycles. From tx_end rise to done: 2 cycles.
- Back-to-back requests from one requester are re-arbitrated after GAP. Round-robin bounds wait to NUM_REQ-1 transactions.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'hA5; SPI model returns 8'h3C. Required: m_tx_start one pulse 2 cycles after req; m_data_in=8'hA5; grant=0001; done[0] pulse 2 cycles after tx_end rise; rx_data=8'h3C; err=0.
- All request: req=4'b1111 held, each requester reacquiring after its done. Required: grant order 0,1,2,3,0; exactly one grant bit at a time; GAP=2 idle cycles between DONE and the next START.
- Timeout: m_tx_end held 0 after start. Required: DONE after 64 BUSY cycles with done[sel] and err pulsed; rx_data=8'h00; next request served normally.
- Simultaneous: tx_end rise on the last timeout cycle. Required: CAPTURE path taken; err=0; rx_data=m_data_out.
- Reset mid-BUSY: assert reset during transfer. Required: all outputs 0 immediately (async), no done pulse; after release, req=4'b0100 gets grant=0100 (pointer reset ⇒ search from 0).
- Request withdrawn: req[2] drops during BUSY with req_data=8'h5A. Required: transfer completes, done[2] pulses, rx_data captured, no re-grant to 2.
